// File: rtl/score_display_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// score_display_ctrl_pkg
// Shared definitions for the score display path:
//   - blank code and digit count used by the display multiplexer
//   - active-low one-hot anode select constants (bit0 = units digit)
//   - conversion FSM state encoding
//   - helper functions: double-dabble step, leading-zero blanking,
//     anode decode and digit selection
// -----------------------------------------------------------------------------
package score_display_ctrl_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         NUM_DIGITS = 4;

    localparam logic [3:0] SEL_D0 = 4'b1110;
    localparam logic [3:0] SEL_D1 = 4'b1101;
    localparam logic [3:0] SEL_D2 = 4'b1011;
    localparam logic [3:0] SEL_D3 = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    // One double-dabble iteration: correct every nibble >= 5, then shift in
    // the next binary bit at the LSB.
    function automatic logic [15:0] dd_step(input logic [15:0] acc,
                                            input logic        bit_in);
        logic [15:0] adj;
        adj = acc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return {adj[14:0], bit_in};
    endfunction

    // Replace leading zero digits with the blank code; the units digit is
    // always kept so that a value of zero still shows "0".
    function automatic logic [15:0] blank_lz(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[15:12] == 4'd0) r[15:12] = BLANK_CODE;
        if (d[15:8]  == 8'd0) r[11:8]  = BLANK_CODE;
        if (d[15:4]  == 12'd0) r[7:4]  = BLANK_CODE;
        return r;
    endfunction

    function automatic logic [3:0] anode_sel(input logic [1:0] slot);
        logic [3:0] r;
        case (slot)
            2'd0:    r = SEL_D0;
            2'd1:    r = SEL_D1;
            2'd2:    r = SEL_D2;
            default: r = SEL_D3;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] digit_pick(input logic [15:0] d,
                                              input logic [1:0]  slot);
        logic [3:0] r;
        case (slot)
            2'd0:    r = d[3:0];
            2'd1:    r = d[7:4];
            2'd2:    r = d[11:8];
            default: r = d[15:12];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/score_display_ctrl_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one bit per clock.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start_i  in   launch a conversion (accepted in IDLE, or in DONE as restart)
//   bin_i    in   binary value, saturated to MAX_DISP when latched
//   busy_o   out  high from the accepting edge until the DONE edge that
//                 does not restart
//   done_o   out  high for the single DONE cycle; bcd_o is final then
//   bcd_o    out  4-digit BCD accumulator
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import score_display_ctrl_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int MAX_DISP = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      bcd_o
);

    localparam int               ITER_W    = (BIN_W > 2) ? $clog2(BIN_W) : 1;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0]  MAX_BIN   = BIN_W'(MAX_DISP);

    conv_state_e       state_q;
    logic [BIN_W-1:0]  bin_q;
    logic [15:0]       acc_q;
    logic [ITER_W-1:0] iter_q;
    logic              busy_q;
    logic              done_q;

    function automatic logic [BIN_W-1:0] sat(input logic [BIN_W-1:0] v);
        return (v > MAX_BIN) ? MAX_BIN : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            iter_q  <= '0;
            acc_q   <= '0;
            bin_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        bin_q   <= sat(bin_i);
                        acc_q   <= '0;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    acc_q  <= dd_step(acc_q, bin_q[BIN_W-1]);
                    bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == LAST_ITER) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // A queued value restarts straight away so busy never dips.
                    if (start_i) begin
                        bin_q   <= sat(bin_i);
                        acc_q   <= '0;
                        iter_q  <= '0;
                        state_q <= ST_CONV;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = acc_q;

endmodule

// File: rtl/score_display_ctrl.sv
// -----------------------------------------------------------------------------
// score_display_ctrl
// Converts a binary score to 4 BCD digits, blanks leading zeros and scans
// the digits onto a shared 4-bit digit bus with active-low anode selects.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   score      in   binary score (saturated to MAX_DISP for display)
//   score_vld  in   one-cycle load strobe for score
//   busy       out  conversion in progress
//   digit_out  out  BCD digit of the current slot, 4'hF = blank
//   ssd_ctl    out  active-low one-hot anode select, bit0 = units digit
// -----------------------------------------------------------------------------
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000,
    parameter int MAX_DISP = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] score,
    input  logic             score_vld,
    output logic             busy,
    output logic [3:0]       digit_out,
    output logic [3:0]       ssd_ctl
);

    localparam int               CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic             conv_start;
    logic [BIN_W-1:0] conv_bin;
    logic             conv_busy;
    logic             conv_done;
    logic [15:0]      conv_bcd;

    logic             pend_vld_q, pend_vld_d;
    logic [BIN_W-1:0] pend_val_q, pend_val_d;
    logic [15:0]      disp_q,     disp_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       slot_q,     slot_d;
    logic [3:0]       ssd_ctl_q,  ssd_ctl_d;
    logic [3:0]       digit_q,    digit_d;

    // A fresh strobe while idle goes straight in; otherwise the pending value
    // launches once the engine is idle or in its DONE cycle.
    always_comb begin
        conv_start = (score_vld && !conv_busy) ||
                     (pend_vld_q && (!conv_busy || conv_done));
        conv_bin   = (score_vld && !conv_busy) ? score : pend_val_q;
    end

    bin2bcd_seq #(
        .BIN_W    (BIN_W),
        .MAX_DISP (MAX_DISP)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .bin_i   (conv_bin),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Single-entry pending slot: latest strobe while busy wins. Busy is
    // still high in the DONE cycle, so a strobe there is queued as well.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        if (score_vld && conv_busy) begin
            pend_vld_d = 1'b1;
            pend_val_d = score;
        end else if (conv_start) begin
            pend_vld_d = 1'b0;
        end
    end

    always_comb begin
        disp_d = conv_done ? conv_bcd : disp_q;
    end

    // Scan divider and slot rotation; outputs are built from the next slot
    // so anode and digit registers always change together.
    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            slot_d = slot_q + 2'd1;
        end else begin
            cnt_d  = cnt_q + 1'b1;
            slot_d = slot_q;
        end
        ssd_ctl_d = anode_sel(slot_d);
        digit_d   = digit_pick(blank_lz(disp_q), slot_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            disp_q     <= '0;
            cnt_q      <= '0;
            slot_q     <= 2'd0;
            ssd_ctl_q  <= SEL_D0;
            digit_q    <= 4'd0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            disp_q     <= disp_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            ssd_ctl_q  <= ssd_ctl_d;
            digit_q    <= digit_d;
        end
    end

    assign busy      = conv_busy;
    assign digit_out = digit_q;
    assign ssd_ctl   = ssd_ctl_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_display_ctrl
// Directed bench for score_display_ctrl with SCAN_DIV=4. Expected display
// updates (value + cycle) are queued when a strobe is driven; a monitor logs
// every change of the display registers, and the two queues are matched.
// -----------------------------------------------------------------------------
module tb_score_display_ctrl;

    localparam int BIN_W    = 14;
    localparam int SCAN_DIV = 4;
    localparam int MAX_DISP = 9999;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [BIN_W-1:0] score = '0;
    logic             score_vld = 1'b0;
    logic             busy;
    logic [3:0]       digit_out;
    logic [3:0]       ssd_ctl;

    always #5 clk = ~clk;

    score_display_ctrl #(
        .BIN_W    (BIN_W),
        .SCAN_DIV (SCAN_DIV),
        .MAX_DISP (MAX_DISP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .score     (score),
        .score_vld (score_vld),
        .busy      (busy),
        .digit_out (digit_out),
        .ssd_ctl   (ssd_ctl)
    );

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } upd_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    upd_t exp_q[$];
    upd_t obs_q[$];
    logic        mon_en    = 1'b0;
    logic [15:0] prev_disp = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && (dut.disp_q !== prev_disp)) begin
            obs_q.push_back('{dut.disp_q, cyc});
            prev_disp = dut.disp_q;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_bcd(input int s);
        int v;
        v = (s > MAX_DISP) ? MAX_DISP : s;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] model_scan(input int s);
        logic [15:0] b;
        logic [15:0] r;
        b = model_bcd(s);
        r = b;
        if (b[15:12] == 0) begin
            r[15:12] = 4'hF;
            if (b[11:8] == 0) begin
                r[11:8] = 4'hF;
                if (b[7:4] == 0) r[7:4] = 4'hF;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_sel(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << s);
    endfunction

    task automatic strobe(input int s, output int k);
        @(negedge clk);
        score     = BIN_W'(s);
        score_vld = 1'b1;
        @(posedge clk);
        #1;
        k         = cyc;
        score_vld = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int low_cyc);
        bit seen;
        seen    = 1'b0;
        low_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                seen    = 1'b1;
                low_cyc = cyc;
                break;
            end
        end
        if (!seen) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain(input string tag);
        upd_t e;
        upd_t o;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_disp_val"}, 32'(o.val), 32'(e.val));
            chk({tag, "_disp_cyc"}, 32'(o.cyc), 32'(e.cyc));
        end
        chk({tag, "_unexpected_updates"}, 32'(obs_q.size()), 32'd0);
        chk({tag, "_missing_updates"}, 32'(exp_q.size()), 32'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_scan(input string tag, input logic [15:0] exp);
        bit found;
        for (int s = 0; s < 4; s++) begin
            found = 1'b0;
            for (int i = 0; i < 4 * SCAN_DIV + 4; i++) begin
                @(negedge clk);
                if (ssd_ctl === exp_sel(s)) begin
                    found = 1'b1;
                    break;
                end
            end
            chk({tag, "_slot_found"}, 32'(found), 32'd1);
            chk({tag, "_digit"}, 32'(digit_out), 32'(exp[4*s +: 4]));
        end
    endtask

    initial begin
        int k;
        int k1;
        int kx;
        int low;
        logic [15:0] idle_pat;

        // Reset held for three edges
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ssd_ctl", 32'(ssd_ctl), 32'(4'b1110));
        chk("rst_digit", 32'(digit_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Release: slot advances every SCAN_DIV clocks, wrapping 3 -> 0
        rst_n    = 1'b1;
        idle_pat = 16'hFFF0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            chk("scan_ssd_ctl", 32'(ssd_ctl), 32'(exp_sel((j / 4) % 4)));
            chk("scan_digit", 32'(digit_out), 32'(idle_pat[4*((j / 4) % 4) +: 4]));
        end
        mon_en = 1'b1;

        // 1234: busy length, latency, digit order
        strobe(1234, k);
        exp_q.push_back('{model_bcd(1234), k + 15});
        wait_idle(40, low);
        chk("busy_len_1234", 32'(low - k), 32'd15);
        repeat (2) @(negedge clk);
        drain("s1234");
        check_scan("scan1234", model_scan(1234));

        // 7: leading zeros blanked
        strobe(7, k);
        exp_q.push_back('{model_bcd(7), k + 15});
        wait_idle(40, low);
        repeat (2) @(negedge clk);
        drain("s7");
        check_scan("scan7", model_scan(7));

        // 1005: inner zeros kept
        strobe(1005, k);
        exp_q.push_back('{model_bcd(1005), k + 15});
        wait_idle(40, low);
        repeat (2) @(negedge clk);
        drain("s1005");
        check_scan("scan1005", model_scan(1005));

        // 16383: saturates to 9999
        strobe(16383, k);
        exp_q.push_back('{model_bcd(16383), k + 15});
        wait_idle(40, low);
        repeat (2) @(negedge clk);
        drain("s16383");
        check_scan("scan16383", model_scan(16383));

        // 42, then 99 and 500 while busy: 99 is overwritten
        strobe(42, k1);
        exp_q.push_back('{model_bcd(42), k1 + 15});
        repeat (3) @(negedge clk);
        strobe(99, kx);
        repeat (3) @(negedge clk);
        strobe(500, kx);
        exp_q.push_back('{model_bcd(500), k1 + 30});
        wait_idle(80, low);
        chk("busy_len_b2b", 32'(low - k1), 32'd30);
        repeat (2) @(negedge clk);
        drain("b2b");
        check_scan("scan500", model_scan(500));

        // Reset during conversion of 8888
        strobe(8888, k);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back('{16'h0000, cyc});
        repeat (2) @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ssd_ctl", 32'(ssd_ctl), 32'(4'b1110));
        chk("midrst_digit", 32'(digit_out), 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        drain("midrst");
        check_scan("scan_after_rst", model_scan(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
